// File: rtl/arm_run_ctrl.sv
// rtl/arm_run_ctrl.sv - run/halt/single-step sequencer and cycle counter for the pipelined ARM core
// Optional breakpoint freeze on IF-stage PC match: define ARM_RUN_CTRL_BREAKPOINT_EN.
module arm_run_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic [PC_W-1:0]  pc_if,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             core_rst,
  output logic             core_en,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_HALT     = 3'd1,
    S_RUN      = 3'd2,
    S_STEP     = 3'd3,
    S_BREAK    = 3'd4
  } state_t;

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_t            cur;
  state_t            nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              run_q;
  logic              step_q;
  logic              run_rise;
  logic              step_rise;
  logic              bp_hit;

  assign run_rise  = run_btn & ~run_q;
  assign step_rise = step_btn & ~step_q;

`ifdef ARM_RUN_CTRL_BREAKPOINT_EN
  logic bp_skip;

  // bp_skip lets the first RUN cycle out of BREAK fetch past bp_addr.
  assign bp_hit = bp_valid & (pc_if == bp_addr) & ~bp_skip & (cur == S_RUN);
`else
  logic unused_bp;

  assign unused_bp = ^{pc_if, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      S_RST_HOLD: if (hold_cnt == HOLD_LAST) nxt = S_HALT;
      S_HALT, S_BREAK: begin
        if (run_rise)       nxt = S_RUN;
        else if (step_rise) nxt = S_STEP;
      end
      // A run edge beats a simultaneous breakpoint hit.
      S_RUN: begin
        if (run_rise)    nxt = S_HALT;
        else if (bp_hit) nxt = S_BREAK;
      end
      S_STEP:  nxt = S_HALT;
      default: nxt = S_RST_HOLD;
    endcase
  end

  assign core_en = ((cur == S_RUN) & ~bp_hit) | (cur == S_STEP);
  assign state   = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_RST_HOLD;
      hold_cnt  <= '0;
      run_q     <= 1'b1;
      step_q    <= 1'b1;
      core_rst  <= 1'b1;
      halted    <= 1'b0;
      cycle_cnt <= '0;
`ifdef ARM_RUN_CTRL_BREAKPOINT_EN
      bp_skip   <= 1'b0;
`endif
    end else begin
      run_q    <= run_btn;
      step_q   <= step_btn;
      cur      <= nxt;
      core_rst <= (nxt == S_RST_HOLD);
      halted   <= (nxt == S_HALT) | (nxt == S_BREAK);
      if ((cur == S_RST_HOLD) && (nxt == S_RST_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
      if (core_en)
        cycle_cnt <= cycle_cnt + 1'b1;
`ifdef ARM_RUN_CTRL_BREAKPOINT_EN
      if ((cur == S_BREAK) && (nxt == S_RUN))
        bp_skip <= 1'b1;
      else if (cur == S_RUN)
        bp_skip <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_arm_run_ctrl.sv
// tb/tb_arm_run_ctrl.sv - scoreboard bench for arm_run_ctrl (RST_CYCLES=16, CNT_W=4)
module tb_arm_run_ctrl;

`ifdef ARM_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        run_btn;
  logic        step_btn;
  logic [31:0] pc_if;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        core_rst;
  logic        core_en;
  logic        halted;
  logic [2:0]  state;
  logic [3:0]  cycle_cnt;
  logic [31:0] pc;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       crst;
    logic       en;
    logic       hlt;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  arm_run_ctrl #(.RST_CYCLES(16), .CNT_W(4), .PC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_btn   (run_btn),
    .step_btn  (step_btn),
    .pc_if     (pc_if),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .halted    (halted),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toy core: PC advances by 4 on every enabled cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst)         pc <= 32'h0;
    else if (core_en) pc <= pc + 32'd4;
  end
  assign pc_if = pc;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if ({state, core_rst, core_en, halted, cycle_cnt} !== {e.st, e.crst, e.en, e.hlt, e.cnt}) begin
        bad++;
        $display("FAIL %s: got state=%0d core_rst=%b core_en=%b halted=%b cnt=%0d, want state=%0d core_rst=%b core_en=%b halted=%b cnt=%0d",
                 e.name, state, core_rst, core_en, halted, cycle_cnt, e.st, e.crst, e.en, e.hlt, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [2:0] st, input logic crst,
                      input logic en, input logic hlt, input logic [3:0] cnt);
    exp_t e;
    e.name = nm; e.st = st; e.crst = crst; e.en = en; e.hlt = hlt; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (16) tick();
    push("reset_to_halt", 3'd1, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  initial begin
    rst = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
    bp_addr = 32'h0000_0010; bp_valid = 1'b1;
    tick();
    push("reset_values", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b1;
    tick();
    push("hold_first", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (14) tick();
    push("hold_15th", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    push("hold_done", 3'd1, 1'b0, 1'b0, 1'b1, 4'd0);

    run_btn = 1'b1; tick();
    push("run_enter", 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
    run_btn = 1'b0; repeat (5) tick();
    push("run_mid", 3'd2, 1'b0, 1'b1, 1'b0, 4'd5);
    repeat (4) tick();
    run_btn = 1'b1; tick();
    push("run_halt", 3'd1, 1'b0, 1'b0, 1'b1, 4'd10);
    run_btn = 1'b0; tick();
    push("halt_stays", 3'd1, 1'b0, 1'b0, 1'b1, 4'd10);

    run_btn = 1'b1; tick();
    push("run_enter2", 3'd2, 1'b0, 1'b1, 1'b0, 4'd10);
    tick();
    rst = 1'b0; #1;
    push("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b1;
    repeat (16) tick();
    push("held_btn_halt", 3'd1, 1'b0, 1'b0, 1'b1, 4'd0);
    repeat (3) tick();
    push("held_btn_no_run", 3'd1, 1'b0, 1'b0, 1'b1, 4'd0);
    run_btn = 1'b0; tick();

    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1; tick();
      push("step_en", 3'd3, 1'b0, 1'b1, 1'b0, 4'(i));
      tick();
      push("step_back", 3'd1, 1'b0, 1'b0, 1'b1, 4'(i + 1));
      repeat (3) tick();
      step_btn = 1'b0; tick();
    end
    push("step_total", 3'd1, 1'b0, 1'b0, 1'b1, 4'd3);

    run_btn = 1'b1; tick();
    push("run_enter3", 3'd2, 1'b0, 1'b1, 1'b0, 4'd3);
    run_btn = 1'b0; step_btn = 1'b1; tick();
    push("step_in_run", 3'd2, 1'b0, 1'b1, 1'b0, 4'd4);
    step_btn = 1'b0; tick();
    run_btn = 1'b1; tick();
    push("run_halt2", 3'd1, 1'b0, 1'b0, 1'b1, 4'd6);
    run_btn = 1'b0; tick();

    run_btn = 1'b1; step_btn = 1'b1; tick();
    push("both_edges_run", 3'd2, 1'b0, 1'b1, 1'b0, 4'd6);
    run_btn = 1'b0; step_btn = 1'b0; tick();
    run_btn = 1'b1; tick();
    push("run_halt3", 3'd1, 1'b0, 1'b0, 1'b1, 4'd8);
    run_btn = 1'b0; tick();

    do_reset();
    run_btn = 1'b1; tick();
    run_btn = 1'b0; repeat (16) tick();
    push("wrap_zero", 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
    run_btn = 1'b1; tick();
    push("wrap_one", 3'd1, 1'b0, 1'b0, 1'b1, 4'd1);
    run_btn = 1'b0; tick();

    do_reset();
    run_btn = 1'b1; tick();
    run_btn = 1'b0; repeat (3) tick();
    tick();
    push("bp_match", 3'd2, 1'b0, !BP, 1'b0, 4'd4);
    tick();
    push("bp_break", BP ? 3'd4 : 3'd2, 1'b0, !BP, BP, BP ? 4'd4 : 4'd5);
`ifdef ARM_RUN_CTRL_BREAKPOINT_EN
    run_btn = 1'b1; tick();
    push("bp_skip_cycle", 3'd2, 1'b0, 1'b1, 1'b0, 4'd4);
    run_btn = 1'b0; tick();
    push("bp_past", 3'd2, 1'b0, 1'b1, 1'b0, 4'd5);
    tick();
    push("bp_past2", 3'd2, 1'b0, 1'b1, 1'b0, 4'd6);
    run_btn = 1'b1; tick();
    push("bp_run_halt", 3'd1, 1'b0, 1'b0, 1'b1, 4'd7);
`else
    repeat (2) tick();
    push("no_bp_runs", 3'd2, 1'b0, 1'b1, 1'b0, 4'd7);
    run_btn = 1'b1; tick();
    push("no_bp_halt", 3'd1, 1'b0, 1'b0, 1'b1, 4'd8);
`endif
    run_btn = 1'b0; tick();

    do_reset();
    run_btn = 1'b1; tick();
    run_btn = 1'b0; repeat (4) tick();
    run_btn = 1'b1; tick();
    push("run_vs_bp", 3'd1, 1'b0, 1'b0, 1'b1, BP ? 4'd4 : 4'd5);
    run_btn = 1'b0; tick();

    repeat (2) tick();
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
